// File: rtl/camera_capture_gen.sv
// Camera byte-bus capture: packs href-qualified bytes into BUS_W-bit words,
// flushes short rows with byte enables, and tracks frame slot / HDR exposure.
module camera_capture_gen #(
  parameter int BUS_W     = 128,
  parameter int NUM_SLOTS = 6,
  parameter int NUM_EXP   = 3,
  parameter int EXP_ROW   = 400,
  parameter int ROW_W     = 10
) (
  input  logic                                               p_clk,
  input  logic                                               rst_n,
  input  logic [7:0]                                         data,
  input  logic                                               href,
  input  logic                                               vsync,
  input  logic                                               take_pic,
  input  logic                                               hdr_en,
  output logic [BUS_W-1:0]                                   p_data,
  output logic [BUS_W/8-1:0]                                 byte_en,
  output logic                                               data_valid,
  output logic                                               row_done,
  output logic                                               frame_done,
  output logic                                               short_row,
  output logic [ROW_W-1:0]                                   row_cnt,
  output logic [$clog2(NUM_SLOTS > 1 ? NUM_SLOTS : 2)-1:0]   frame_slot,
  output logic [$clog2(NUM_EXP > 1 ? NUM_EXP : 2)-1:0]       exp_idx,
  output logic                                               change_exp
);

  localparam int LANES  = BUS_W / 8;
  localparam int PTR_W  = $clog2(LANES);
  localparam int SLOT_W = $clog2(NUM_SLOTS > 1 ? NUM_SLOTS : 2);
  localparam int EXP_W  = $clog2(NUM_EXP > 1 ? NUM_EXP : 2);

  typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH} state_t;

  state_t             state_q;
  logic [PTR_W-1:0]   ptr_q;
  logic [BUS_W-1:0]   word_q;
  logic [BUS_W-1:0]   p_data_q;
  logic [LANES-1:0]   byte_en_q;
  logic               dv_q, row_done_q, frame_done_q, short_row_q, change_exp_q;
  logic [ROW_W-1:0]   row_cnt_q;
  logic [SLOT_W-1:0]  slot_q;
  logic [EXP_W-1:0]   exp_q;
  logic               armed_q;
  logic               href_q, vsync_q;

  logic [BUS_W-1:0]   word_d;
  logic [BUS_W-1:0]   flush_data_d;
  logic [LANES-1:0]   flush_be_d;
  logic               row_fall, frame_rise;

  assign row_fall   = href_q & ~href;
  assign frame_rise = ~vsync_q & vsync;

  // Word with the incoming byte inserted, and the masked partial word for a flush.
  always_comb begin
    word_d       = word_q;
    flush_data_d = '0;
    flush_be_d   = '0;
    for (int i = 0; i < LANES; i++) begin
      if (PTR_W'(i) == ptr_q) word_d[i*8 +: 8] = data;
      if (PTR_W'(i) < ptr_q) begin
        flush_data_d[i*8 +: 8] = word_q[i*8 +: 8];
        flush_be_d[i]          = 1'b1;
      end
    end
  end

  always_ff @(posedge p_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      word_q       <= '0;
      p_data_q     <= '0;
      byte_en_q    <= '0;
      dv_q         <= 1'b0;
      row_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
      short_row_q  <= 1'b0;
      change_exp_q <= 1'b0;
      row_cnt_q    <= '0;
      slot_q       <= '0;
      exp_q        <= '0;
      armed_q      <= 1'b0;
      href_q       <= 1'b0;
      vsync_q      <= 1'b1;
    end else if (take_pic) begin
      // Capture restart: ring and exposure indices survive.
      state_q      <= IDLE;
      ptr_q        <= '0;
      word_q       <= '0;
      p_data_q     <= '0;
      byte_en_q    <= '0;
      dv_q         <= 1'b0;
      row_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
      short_row_q  <= 1'b0;
      change_exp_q <= 1'b0;
      row_cnt_q    <= '0;
      armed_q      <= 1'b0;
      href_q       <= 1'b0;
      vsync_q      <= 1'b1;
    end else begin
      href_q       <= href;
      vsync_q      <= vsync;
      row_done_q   <= row_fall;
      frame_done_q <= frame_rise;
      dv_q         <= 1'b0;
      short_row_q  <= 1'b0;
      change_exp_q <= 1'b0;

      if (frame_rise) begin
        slot_q <= (slot_q == SLOT_W'(NUM_SLOTS - 1)) ? '0 : slot_q + 1'b1;
        if (hdr_en) exp_q <= (exp_q == EXP_W'(NUM_EXP - 1)) ? '0 : exp_q + 1'b1;
        else        exp_q <= '0;
      end

      case (state_q)
        IDLE: begin
          ptr_q     <= '0;
          row_cnt_q <= '0;
          if (!vsync) begin
            state_q <= CAPTURE;
            if (hdr_en) armed_q <= 1'b1;
          end
        end
        CAPTURE: begin
          if (vsync) begin
            state_q <= IDLE;
            ptr_q   <= '0;
          end else begin
            if (href) begin
              word_q <= word_d;
              if (ptr_q == PTR_W'(LANES - 1)) begin
                p_data_q  <= word_d;
                byte_en_q <= '1;
                dv_q      <= 1'b1;
                ptr_q     <= '0;
              end else begin
                ptr_q <= ptr_q + 1'b1;
              end
            end else if (row_fall) begin
              if (row_cnt_q != '1) row_cnt_q <= row_cnt_q + 1'b1;
              if (ptr_q != '0) begin
                p_data_q    <= flush_data_d;
                byte_en_q   <= flush_be_d;
                dv_q        <= 1'b1;
                short_row_q <= 1'b1;
                ptr_q       <= '0;
                state_q     <= FLUSH;
              end
            end
            if (hdr_en && armed_q && row_cnt_q == ROW_W'(EXP_ROW)) begin
              change_exp_q <= 1'b1;
              armed_q      <= 1'b0;
            end
          end
        end
        FLUSH: begin
          ptr_q   <= '0;
          state_q <= vsync ? IDLE : CAPTURE;
        end
        default: state_q <= IDLE;
      endcase

      if (!hdr_en) armed_q <= 1'b0;
    end
  end

  assign p_data     = p_data_q;
  assign byte_en    = byte_en_q;
  assign data_valid = dv_q;
  assign row_done   = row_done_q;
  assign frame_done = frame_done_q;
  assign short_row  = short_row_q;
  assign row_cnt    = row_cnt_q;
  assign frame_slot = slot_q;
  assign exp_idx    = exp_q;
  assign change_exp = change_exp_q;

endmodule

// File: tb/tb_camera_capture_gen.sv
// Scoreboard bench for camera_capture_gen: a byte-level model queues expected
// words as rows are driven; a monitor pops and compares on every data_valid.
module tb_camera_capture_gen;
  localparam int BUS_W = 128, LANES = 16, NUM_SLOTS = 6, NUM_EXP = 3;
  localparam int EXP_ROW = 400, ROW_W = 10;

  logic              p_clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        data = '0;
  logic              href = 1'b0, vsync = 1'b1, take_pic = 1'b0, hdr_en = 1'b0;
  logic [BUS_W-1:0]  p_data;
  logic [LANES-1:0]  byte_en;
  logic              data_valid, row_done, frame_done, short_row, change_exp;
  logic [ROW_W-1:0]  row_cnt;
  logic [2:0]        frame_slot;
  logic [1:0]        exp_idx;

  camera_capture_gen #(.BUS_W(BUS_W), .NUM_SLOTS(NUM_SLOTS), .NUM_EXP(NUM_EXP),
                       .EXP_ROW(EXP_ROW), .ROW_W(ROW_W)) dut (
    .p_clk(p_clk), .rst_n(rst_n), .data(data), .href(href), .vsync(vsync),
    .take_pic(take_pic), .hdr_en(hdr_en), .p_data(p_data), .byte_en(byte_en),
    .data_valid(data_valid), .row_done(row_done), .frame_done(frame_done),
    .short_row(short_row), .row_cnt(row_cnt), .frame_slot(frame_slot),
    .exp_idx(exp_idx), .change_exp(change_exp));

  always #5 p_clk = ~p_clk;

  typedef struct { logic [BUS_W-1:0] d; logic [LANES-1:0] be; logic sr; } exp_t;
  exp_t sb[$];
  exp_t me;

  int compared = 0, mismatched = 0;
  int dv_cnt = 0, rd_cnt = 0, fd_cnt = 0, sr_cnt = 0, ce_cnt = 0;
  logic prev_dv = 1'b0;
  logic [BUS_W-1:0] acc = '0;
  int acc_n = 0;

  task automatic cyc();
    @(negedge p_clk); #1;
  endtask

  task automatic push_word(input logic [LANES-1:0] be, input logic sr);
    exp_t e;
    e.d = acc; e.be = be; e.sr = sr;
    sb.push_back(e);
    acc = '0; acc_n = 0;
  endtask

  task automatic drive_byte(input logic [7:0] b);
    href = 1'b1; data = b;
    acc[acc_n*8 +: 8] = b;
    acc_n++;
    if (acc_n == LANES) push_word('1, 1'b0);
    cyc();
  endtask

  task automatic end_row();
    logic [LANES-1:0] m;
    href = 1'b0; data = '0;
    if (acc_n != 0) begin
      m = '0;
      for (int i = 0; i < acc_n; i++) m[i] = 1'b1;
      push_word(m, 1'b1);
    end
    cyc(); cyc();
  endtask

  task automatic send_row(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) drive_byte(base + 8'(i));
    end_row();
  endtask

  task automatic start_frame();
    vsync = 1'b0; cyc(); cyc();
  endtask

  task automatic end_frame();
    href = 1'b0; vsync = 1'b1; acc = '0; acc_n = 0;
    cyc(); cyc(); cyc();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; href = 1'b0; vsync = 1'b1; data = '0; take_pic = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    sb.delete(); acc = '0; acc_n = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    compared++; if (p_data !== '0) begin mismatched++; $display("FAIL reset_p_data: got %0h want 0", p_data); end
    compared++; if (byte_en !== '0) begin mismatched++; $display("FAIL reset_byte_en: got %0h want 0", byte_en); end
    compared++; if ({data_valid, row_done, frame_done, short_row, change_exp} !== 5'b0) begin
      mismatched++; $display("FAIL reset_pulses: got %b want 00000", {data_valid, row_done, frame_done, short_row, change_exp}); end
    compared++; if ({row_cnt, frame_slot, exp_idx} !== '0) begin
      mismatched++; $display("FAIL reset_counters: got %0h/%0h/%0h want 0/0/0", row_cnt, frame_slot, exp_idx); end
  endtask

  task automatic test_basic_frame();
    int dv0, rd0, fd0;
    apply_reset();
    dv0 = dv_cnt; rd0 = rd_cnt; fd0 = fd_cnt;
    start_frame();
    send_row(32, 8'h00);
    send_row(32, 8'h00);
    compared++; if (row_cnt !== 10'd2) begin mismatched++; $display("FAIL basic_row_cnt: got %0d want 2", row_cnt); end
    compared++; if (rd_cnt - rd0 != 2) begin mismatched++; $display("FAIL basic_row_done: got %0d want 2", rd_cnt - rd0); end
    compared++; if (dv_cnt - dv0 != 4) begin mismatched++; $display("FAIL basic_words: got %0d want 4", dv_cnt - dv0); end
    end_frame();
    compared++; if (fd_cnt - fd0 != 1) begin mismatched++; $display("FAIL basic_frame_done: got %0d want 1", fd_cnt - fd0); end
    compared++; if (frame_slot !== 3'd1) begin mismatched++; $display("FAIL basic_slot: got %0d want 1", frame_slot); end
  endtask

  task automatic test_short_row();
    int dv0, sr0;
    dv0 = dv_cnt; sr0 = sr_cnt;
    start_frame();
    send_row(20, 8'h20);
    compared++; if (row_cnt !== 10'd1) begin mismatched++; $display("FAIL short_row_cnt: got %0d want 1", row_cnt); end
    compared++; if (sr_cnt - sr0 != 1) begin mismatched++; $display("FAIL short_pulse: got %0d want 1", sr_cnt - sr0); end
    compared++; if (dv_cnt - dv0 != 2) begin mismatched++; $display("FAIL short_words: got %0d want 2", dv_cnt - dv0); end
    compared++; if (byte_en !== 16'h000F) begin mismatched++; $display("FAIL short_byte_en: got %0h want 000f", byte_en); end
    compared++; if (p_data[BUS_W-1:32] !== '0) begin mismatched++; $display("FAIL short_upper_lanes: got %0h want 0", p_data[BUS_W-1:32]); end
    end_frame();
  endtask

  task automatic test_slot_ring();
    apply_reset();
    for (int f = 0; f < 7; f++) begin
      compared++; if (frame_slot !== 3'(f % NUM_SLOTS)) begin
        mismatched++; $display("FAIL slot_seq_%0d: got %0d want %0d", f, frame_slot, f % NUM_SLOTS); end
      start_frame();
      send_row(16, 8'(f * 16));
      end_frame();
    end
    compared++; if (frame_slot !== 3'd1) begin mismatched++; $display("FAIL slot_seq_7: got %0d want 1", frame_slot); end
  endtask

  task automatic test_hdr();
    int ce0;
    apply_reset();
    hdr_en = 1'b1;
    for (int f = 0; f < 4; f++) begin
      compared++; if (exp_idx !== 2'(f % NUM_EXP)) begin
        mismatched++; $display("FAIL hdr_exp_%0d: got %0d want %0d", f, exp_idx, f % NUM_EXP); end
      ce0 = ce_cnt;
      start_frame();
      for (int r = 0; r < 401; r++) send_row(1, 8'(r));
      if (f == 3) hdr_en = 1'b0;
      end_frame();
      compared++; if (ce_cnt - ce0 != 1) begin mismatched++; $display("FAIL hdr_change_exp_%0d: got %0d want 1", f, ce_cnt - ce0); end
    end
    ce0 = ce_cnt;
    compared++; if (exp_idx !== 2'd0) begin mismatched++; $display("FAIL hdr_off_exp: got %0d want 0", exp_idx); end
    start_frame();
    for (int r = 0; r < 401; r++) send_row(1, 8'(r));
    end_frame();
    compared++; if (ce_cnt - ce0 != 0) begin mismatched++; $display("FAIL hdr_off_change_exp: got %0d want 0", ce_cnt - ce0); end
    compared++; if (exp_idx !== 2'd0) begin mismatched++; $display("FAIL hdr_off_exp_end: got %0d want 0", exp_idx); end
  endtask

  task automatic test_take_pic();
    int dv0, rd0;
    apply_reset();
    start_frame(); send_row(16, 8'h00); end_frame();
    start_frame();
    dv0 = dv_cnt; rd0 = rd_cnt;
    for (int i = 0; i < 5; i++) begin href = 1'b1; data = 8'(i); cyc(); end
    take_pic = 1'b1; data = 8'h05; cyc();
    data = 8'h06; cyc(); data = 8'h07; cyc();
    href = 1'b0; cyc(); cyc();
    take_pic = 1'b0; cyc(); cyc();
    compared++; if (dv_cnt - dv0 != 0) begin mismatched++; $display("FAIL take_pic_words: got %0d want 0", dv_cnt - dv0); end
    compared++; if (rd_cnt - rd0 != 0) begin mismatched++; $display("FAIL take_pic_row_done: got %0d want 0", rd_cnt - rd0); end
    compared++; if (frame_slot !== 3'd1) begin mismatched++; $display("FAIL take_pic_slot: got %0d want 1", frame_slot); end
    compared++; if (row_cnt !== 10'd0) begin mismatched++; $display("FAIL take_pic_row_cnt: got %0d want 0", row_cnt); end
    send_row(16, 8'h80);
    compared++; if (dv_cnt - dv0 != 1) begin mismatched++; $display("FAIL take_pic_resume: got %0d want 1", dv_cnt - dv0); end
    end_frame();
    compared++; if (frame_slot !== 3'd2) begin mismatched++; $display("FAIL take_pic_slot_after: got %0d want 2", frame_slot); end
  endtask

  task automatic test_vsync_discard();
    int dv0, sr0, fd0;
    start_frame();
    dv0 = dv_cnt; sr0 = sr_cnt; fd0 = fd_cnt;
    for (int i = 0; i < 7; i++) drive_byte(8'h60 + 8'(i));
    end_frame();
    compared++; if (dv_cnt - dv0 != 0) begin mismatched++; $display("FAIL vsync_discard_words: got %0d want 0", dv_cnt - dv0); end
    compared++; if (sr_cnt - sr0 != 0) begin mismatched++; $display("FAIL vsync_discard_short: got %0d want 0", sr_cnt - sr0); end
    compared++; if (fd_cnt - fd0 != 1) begin mismatched++; $display("FAIL vsync_discard_frame_done: got %0d want 1", fd_cnt - fd0); end
    start_frame();
    send_row(16, 8'hA0);
    end_frame();
  endtask

  task automatic test_row_sat();
    apply_reset();
    start_frame();
    for (int r = 0; r < 1025; r++) send_row(1, 8'(r));
    compared++; if (row_cnt !== 10'h3FF) begin mismatched++; $display("FAIL row_sat: got %0h want 3ff", row_cnt); end
    end_frame();
  endtask

  task automatic test_async_reset();
    start_frame();
    send_row(16, 8'h10);
    send_row(3, 8'h30);
    for (int i = 0; i < 5; i++) begin href = 1'b1; data = 8'hC0 + 8'(i); cyc(); end
    compared++; if (row_cnt !== 10'd2) begin mismatched++; $display("FAIL async_pre_row_cnt: got %0d want 2", row_cnt); end
    #2 rst_n = 1'b0;
    #1;
    compared++; if ({row_cnt, frame_slot, exp_idx} !== '0) begin
      mismatched++; $display("FAIL async_counters: got %0h/%0h/%0h want 0/0/0", row_cnt, frame_slot, exp_idx); end
    compared++; if (p_data !== '0 || byte_en !== '0) begin
      mismatched++; $display("FAIL async_data: got %0h/%0h want 0/0", p_data, byte_en); end
    href = 1'b0; vsync = 1'b1; cyc(); cyc();
    rst_n = 1'b1; cyc(); cyc();
    compared++; if (sb.size() != 0) begin mismatched++; $display("FAIL async_pending: got %0d want 0", sb.size()); end
    sb.delete(); acc = '0; acc_n = 0;
  endtask

  initial begin
    fork
      forever begin
        @(negedge p_clk);
        if (data_valid) begin
          dv_cnt++;
          compared++;
          if (prev_dv === 1'b1) begin mismatched++; $display("FAIL back_to_back_valid: got 1 want 0"); end
          compared++;
          if (sb.size() == 0) begin
            mismatched++; $display("FAIL unexpected_word: got %0h be %0h want none", p_data, byte_en);
          end else begin
            me = sb.pop_front();
            if (p_data !== me.d || byte_en !== me.be || short_row !== me.sr) begin
              mismatched++;
              $display("FAIL word: got %0h be %0h sr %b want %0h be %0h sr %b", p_data, byte_en, short_row, me.d, me.be, me.sr);
            end
          end
        end
        prev_dv = data_valid;
        if (row_done) rd_cnt++;
        if (frame_done) fd_cnt++;
        if (short_row) sr_cnt++;
        if (change_exp) begin
          ce_cnt++;
          compared++;
          if (row_cnt !== 10'(EXP_ROW)) begin mismatched++; $display("FAIL change_exp_row: got %0d want %0d", row_cnt, EXP_ROW); end
        end
      end
      begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
      end
    join_none

    test_reset();
    test_basic_frame();
    test_short_row();
    test_slot_ring();
    test_hdr();
    test_take_pic();
    test_vsync_discard();
    test_row_sat();
    test_async_reset();
    cyc();
    compared++; if (sb.size() != 0) begin mismatched++; $display("FAIL leftover_words: got %0d want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/camera_capture_gen.md
Name: camera_capture_gen

Overview:
- Parametrised successor to the camera pixel-capture block: samples the 8-bit camera bus (href/vsync framing) and packs bytes into BUS_W-bit memory words for the DDR write path.
- Adds over the previous generation:
  - configurable word width;
  - partial-word flush with byte enables at short row ends;
  - an N-slot frame-buffer ring index;
  - a configurable HDR exposure bracket;
  - row count output.
- Sits between the camera pins (p_clk domain) and the DDR write FIFO.

Parameters:
- BUS_W, 128, packed output word width; multiple of 8, 16..256.
- NUM_SLOTS, 6, number of frame-buffer slots in the ring; ≥2.
- NUM_EXP, 3, exposures per HDR bracket; ≥1.
- EXP_ROW, 400, row index at which the change_exp pulse fires.
- ROW_W, 10, width of the row counter.

Ports:
- p_clk  in  1  camera pixel clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- data  in  8  camera byte bus.
- href  in  1  row-valid; high while bytes are valid.
- vsync  in  1  frame sync; low during an active frame.
- take_pic  in  1  synchronous clear of capture; freezes the ring and exposure indices.
- hdr_en  in  1  enables exposure cycling and change_exp.
- p_data  out  BUS_W  packed word; byte 0 of each word is in [7:0].
- byte_en  out  BUS_W/8  valid-lane mask accompanying p_data.
- data_valid  out  1  one-cycle qualifier for p_data/byte_en.
- row_done  out  1  pulse on falling edge of href.
- frame_done  out  1  pulse on rising edge of vsync.
- short_row  out  1  pulse when a row ends on a non-word boundary.
- row_cnt  out  ROW_W  rows completed in the current frame.
- frame_slot  out  max(1,clog2(NUM_SLOTS))  slot currently being written.
- exp_idx  out  max(1,clog2(NUM_EXP))  exposure index of the current frame.
- change_exp  out  1  one-cycle request to reprogram exposure.

Behaviour:
- Reset (async, rst_n=0):
  - all outputs 0; p_data=0; byte_en=0; state IDLE; lane pointer 0.
  - internal registers q_vsync=1 and q_href=0, so no edge is flagged on release.
- take_pic=1 (synchronous):
  - Same clears as reset.
  - frame_slot and exp_idx are held, not cleared.
  - No edge pulses while take_pic is high.
- Edge detection:
  - q_href and q_vsync are the previous-cycle samples.
  - row_done = q_href & ~href; frame_done = ~q_vsync & vsync.
  - Both are registered, so each pulse asserts the cycle after the sampling edge.
- States:
  - IDLE:
    - Lane pointer set to 0; row_cnt set to 0.
    - Go to CAPTURE when vsync=0.
  - CAPTURE:
    - While href=1, each cycle writes data into lane[ptr], and ptr increments.
    - When ptr = BUS_W/8-1, the next cycle presents data_valid=1 with byte_en all ones, and ptr wraps to 0.
    - On an href falling edge with ptr≠0: go to FLUSH.
    - On an href falling edge with ptr=0: no flush.
    - On every href falling edge: row_cnt increments.
    - vsync=1: go to IDLE, discarding any partial word (no data_valid, no short_row).
  - FLUSH (exactly 1 cycle):
    - data_valid=1; byte_en has ones in lanes 0..ptr-1; unused lanes of p_data are 0; short_row=1.
    - ptr=0; return to CAPTURE, or to IDLE if vsync=1.
- A last byte that completes a word in the same cycle href falls is emitted as a full word; no flush.
- data_valid is never high on two consecutive cycles unless a full word is immediately followed by a flush. That sequence is not reachable because a byte cycle must occur in between.
- Ring index:
  - On each frame_done, frame_slot ← (frame_slot+1) mod NUM_SLOTS.
  - If hdr_en=1, exp_idx ← (exp_idx+1) mod NUM_EXP; otherwise exp_idx ← 0.
- change_exp:
  - A one-cycle pulse when in CAPTURE, hdr_en=1, row_cnt==EXP_ROW, and the per-frame armed flag is set.
  - The pulse clears the armed flag.
  - The flag re-arms in IDLE when vsync=0 and hdr_en=1.
  - If hdr_en=0, the flag is held cleared, so there is no pulse.
- row_cnt saturates at all ones; it does not wrap.
- Reset asserted mid-word or mid-frame: everything clears immediately and no partial word is emitted.

Test Plan:
- BUS_W=128, 1 frame of 2 rows × 32 bytes (bytes 0x00..0x1F) → 4 data_valid pulses; the first p_data = 0x0F0E…0100; byte_en=0xFFFF; row_done×2; frame_done×1 after vsync rises; frame_slot 0→1.
- Row of 20 bytes → 1 full word, then a FLUSH word with byte_en=0x000F, lanes 4..15 = 0, short_row=1; row_cnt=1.
- hdr_en=1, NUM_EXP=3, 4 frames of 401 rows → exp_idx 0,1,2,0; exactly one change_exp per frame, in the cycle after row_cnt reaches 400. hdr_en=0 → no change_exp and exp_idx=0.
- NUM_SLOTS=6, 7 frames → frame_slot sequence 0,1,2,3,4,5,0,1.
- take_pic pulsed mid-row at byte 5 → no data_valid; frame_slot unchanged. After release, the next word starts at lane 0.
- vsync rises with ptr=7 → no flush, no short_row; state IDLE. Async rst_n low mid-frame → all outputs 0 without waiting for a clock edge.
